// File: rtl/seg7_4digits_to_bin.sv
// Four seven-segment codes in, one binary number out: each captured pattern is decoded
// to a BCD digit and folded into an accumulator with one multiply-by-10-and-add step per clock.
module seg7_4digits_to_bin #(
   parameter int N_in       = 7,
   parameter int N_out      = 14,
   parameter bit ACTIVE_LOW = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [N_in-1:0]   D_mi,
   input  logic [N_in-1:0]   D_ce,
   input  logic [N_in-1:0]   D_de,
   input  logic [N_in-1:0]   D_un,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [N_out-1:0]  bin_out,
   output logic [3:0]        err_digits,
   output logic              out_valid,
   input  logic              out_ready
);

   // Handshake: a transfer happens on a rising edge where valid and ready are both high.
   // in_ready is high only in IDLE; out_valid holds with stable data until out_ready is taken.
   typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

   state_t           state, state_next;
   logic [N_in-1:0]  code_q [4];
   logic [N_out-1:0] acc, acc_next, bin_q;
   logic [1:0]       idx;
   logic [3:0]       err_acc, err_next, err_q;
   logic             out_valid_q;

   logic [N_in-1:0]  cur_code, pat;
   logic [3:0]       cur_digit;
   logic             cur_bad;
   logic             accept, last_step, consume;

   always_comb begin
      state_next = state;
      accept     = 1'b0;
      last_step  = 1'b0;
      consume    = 1'b0;
      case (state)
         IDLE: begin
            if (in_valid) begin
               accept     = 1'b1;
               state_next = ACC;
            end
         end
         ACC: begin
            if (idx == 2'd3) begin
               last_step  = 1'b1;
               state_next = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               consume    = 1'b1;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Index 0 is the thousands digit, so the most significant digit enters the accumulator first.
   always_comb begin
      cur_code  = code_q[idx];
      pat       = ACTIVE_LOW ? ~cur_code : cur_code;
      cur_digit = 4'd0;
      cur_bad   = 1'b0;
      case (pat)
         7'h3F: cur_digit = 4'd0;
         7'h06: cur_digit = 4'd1;
         7'h5B: cur_digit = 4'd2;
         7'h4F: cur_digit = 4'd3;
         7'h66: cur_digit = 4'd4;
         7'h6D: cur_digit = 4'd5;
         7'h7D: cur_digit = 4'd6;
         7'h07: cur_digit = 4'd7;
         7'h7F: cur_digit = 4'd8;
         7'h6F: cur_digit = 4'd9;
         7'h00: cur_digit = 4'd0;
         default: begin
            cur_digit = 4'd0;
            cur_bad   = 1'b1;
         end
      endcase
   end

   // err mask is {mi,ce,de,un}, so digit index k maps to bit 3-k.
   always_comb begin
      acc_next = (acc << 3) + (acc << 1) + {{(N_out-4){1'b0}}, cur_digit};
      err_next = err_acc;
      if (cur_bad) err_next[2'd3 - idx] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         acc         <= '0;
         idx         <= 2'd0;
         err_acc     <= 4'd0;
         bin_q       <= '0;
         err_q       <= 4'd0;
         out_valid_q <= 1'b0;
         for (int k = 0; k < 4; k++) code_q[k] <= '0;
      end else begin
         state <= state_next;
         if (accept) begin
            code_q[0] <= D_mi;
            code_q[1] <= D_ce;
            code_q[2] <= D_de;
            code_q[3] <= D_un;
            acc       <= '0;
            idx       <= 2'd0;
            err_acc   <= 4'd0;
         end
         if (state == ACC) begin
            acc     <= acc_next;
            err_acc <= err_next;
            idx     <= idx + 2'd1;
         end
         if (last_step) begin
            bin_q       <= acc_next;
            err_q       <= err_next;
            out_valid_q <= 1'b1;
         end
         if (consume) out_valid_q <= 1'b0;
      end
   end

   assign in_ready   = (state == IDLE);
   assign bin_out    = bin_q;
   assign err_digits = err_q;
   assign out_valid  = out_valid_q;

endmodule

// File: tb/tb_seg7_4digits_to_bin.sv
// Directed bench for seg7_4digits_to_bin with ACTIVE_LOW segment codes.
module tb_seg7_4digits_to_bin;

   logic        clk = 1'b0;
   logic        rst;
   logic [6:0]  d_mi, d_ce, d_de, d_un;
   logic        in_valid;
   logic        in_ready;
   logic [13:0] bin_out;
   logic [3:0]  err_digits;
   logic        out_valid;
   logic        out_ready;

   int n_checks = 0;
   int n_fail   = 0;

   // Active-low codes: 0=40 1=79 2=24 3=30 4=19 5=12 7=78 8=00 9=10 blank=7F
   localparam logic [6:0] C0 = 7'h40, C1 = 7'h79, C2 = 7'h24, C3 = 7'h30, C4 = 7'h19;
   localparam logic [6:0] C5 = 7'h12, C7 = 7'h78, C8 = 7'h00, C9 = 7'h10, CB = 7'h7F;

   seg7_4digits_to_bin #(.N_in(7), .N_out(14), .ACTIVE_LOW(1'b1)) dut (
      .clk(clk), .rst(rst),
      .D_mi(d_mi), .D_ce(d_ce), .D_de(d_de), .D_un(d_un),
      .in_valid(in_valid), .in_ready(in_ready),
      .bin_out(bin_out), .err_digits(err_digits),
      .out_valid(out_valid), .out_ready(out_ready)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // All tasks start and end 1 time unit after a rising edge.
   task automatic do_accept(input logic [6:0] a, input logic [6:0] b,
                            input logic [6:0] c, input logic [6:0] d);
      int n = 0;
      d_mi = a; d_ce = b; d_de = c; d_un = d;
      in_valid = 1'b1;
      while (!in_ready && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      n_checks++;
      if (in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL accept_wait: in_ready=%b required 1", in_ready);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_out(output int cyc);
      cyc = 0;
      while (out_valid !== 1'b1 && cyc < 20) begin
         @(posedge clk); #1;
         cyc++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      d_mi = C1; d_ce = C1; d_de = C1; d_un = C1;
      repeat (2) @(posedge clk);
      #1; rst = 1'b0;
      @(posedge clk); #1;
      n_checks++;
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b required 1", in_ready); end
      n_checks++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b required 0", out_valid); end
      n_checks++;
      if (bin_out !== 14'd0) begin n_fail++; $display("FAIL reset_bin_out: got %0d required 0", bin_out); end
      n_checks++;
      if (err_digits !== 4'b0000) begin n_fail++; $display("FAIL reset_err: got %b required 0000", err_digits); end
   endtask

   task automatic test_basic();
      int cyc;
      out_ready = 1'b1;
      do_accept(C1, C2, C3, C4);
      d_mi = 7'h01; d_ce = 7'h02; d_de = 7'h03; d_un = 7'h04;
      n_checks++;
      if (in_ready !== 1'b0) begin n_fail++; $display("FAIL basic_busy: in_ready=%b required 0", in_ready); end
      wait_out(cyc);
      n_checks++;
      if (cyc !== 4) begin n_fail++; $display("FAIL basic_latency: got %0d cycles required 4", cyc); end
      n_checks++;
      if (bin_out !== 14'd1234) begin n_fail++; $display("FAIL basic_value: got %0d required 1234", bin_out); end
      n_checks++;
      if (err_digits !== 4'b0000) begin n_fail++; $display("FAIL basic_err: got %b required 0000", err_digits); end
      @(posedge clk); #1;
      n_checks++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_drop: out_valid=%b required 0", out_valid); end
      n_checks++;
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL basic_ready: in_ready=%b required 1", in_ready); end
      n_checks++;
      if (bin_out !== 14'd1234) begin n_fail++; $display("FAIL basic_keep: bin_out=%0d required 1234", bin_out); end
   endtask

   task automatic test_blank();
      int cyc;
      out_ready = 1'b1;
      do_accept(CB, CB, C4, C2);
      wait_out(cyc);
      n_checks++;
      if (bin_out !== 14'd42) begin n_fail++; $display("FAIL blank_value: got %0d required 42", bin_out); end
      n_checks++;
      if (err_digits !== 4'b0000) begin n_fail++; $display("FAIL blank_err: got %b required 0000", err_digits); end
      @(posedge clk); #1;
   endtask

   task automatic test_invalid();
      int cyc;
      out_ready = 1'b1;
      do_accept(C9, C9, 7'h7E, C9);
      wait_out(cyc);
      n_checks++;
      if (bin_out !== 14'd9909) begin n_fail++; $display("FAIL invalid_value: got %0d required 9909", bin_out); end
      n_checks++;
      if (err_digits !== 4'b0010) begin n_fail++; $display("FAIL invalid_err: got %b required 0010", err_digits); end
      @(posedge clk); #1;
   endtask

   task automatic test_hold();
      int cyc;
      int bad = 0;
      out_ready = 1'b0;
      do_accept(C8, C8, C8, C8);
      wait_out(cyc);
      n_checks++;
      if (out_valid !== 1'b1 || bin_out !== 14'd8888) begin
         n_fail++; $display("FAIL hold_first: out_valid=%b bin_out=%0d required 1/8888", out_valid, bin_out);
      end
      d_mi = C0; d_ce = C0; d_de = C0; d_un = C5;
      in_valid = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         if (out_valid !== 1'b1 || bin_out !== 14'd8888 || in_ready !== 1'b0) bad++;
      end
      n_checks++;
      if (bad != 0) begin n_fail++; $display("FAIL hold_stable: %0d unstable cycles required 0", bad); end
      // out_ready and in_valid together in DONE must only release, never accept.
      out_ready = 1'b1;
      @(posedge clk); #1;
      n_checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         n_fail++; $display("FAIL hold_release: out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
      end
      // in_valid still high: IDLE re-entry starts the next conversion right away.
      @(posedge clk); #1;
      in_valid = 1'b0;
      n_checks++;
      if (in_ready !== 1'b0) begin n_fail++; $display("FAIL back_to_back_accept: in_ready=%b required 0", in_ready); end
      wait_out(cyc);
      n_checks++;
      if (cyc !== 4 || bin_out !== 14'd5) begin
         n_fail++; $display("FAIL back_to_back_value: cycles=%0d bin_out=%0d required 4/5", cyc, bin_out);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_abort();
      int cyc;
      int seen = 0;
      out_ready = 1'b1;
      do_accept(C1, C2, C3, C4);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      n_checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         n_fail++; $display("FAIL abort_state: out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
      end
      n_checks++;
      if (bin_out !== 14'd0 || err_digits !== 4'b0000) begin
         n_fail++; $display("FAIL abort_clear: bin_out=%0d err=%b required 0/0000", bin_out, err_digits);
      end
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         if (out_valid === 1'b1) seen++;
      end
      n_checks++;
      if (seen != 0) begin n_fail++; $display("FAIL abort_no_output: out_valid seen %0d times required 0", seen); end
      do_accept(C0, C0, C0, C7);
      wait_out(cyc);
      n_checks++;
      if (cyc !== 4 || bin_out !== 14'd7 || err_digits !== 4'b0000) begin
         n_fail++; $display("FAIL abort_next: cycles=%0d bin_out=%0d err=%b required 4/7/0000", cyc, bin_out, err_digits);
      end
      @(posedge clk); #1;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_blank();
      test_invalid();
      test_hold();
      test_reset_abort();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
